// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM state codes and handshake levels.
// Imported by div_unit; the pipeline-wide Stop/ZeroWord/DoubleRegBus names live here too.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic        Stop     = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; stalls the pipeline while busy.
// One quotient bit per cycle on magnitudes, sign fix-up applied once at the end.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CW = $clog2(DATA_W + 1);

  div_state_e           state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [2*DATA_W:0]    working_reg;
  logic [DATA_W-1:0]    divisor_reg;
  logic                 sign1_reg;
  logic                 sign2_reg;
  logic                 signed_reg;

  logic [DATA_W-1:0]    abs1;
  logic [DATA_W-1:0]    abs2;
  logic [DATA_W:0]      diff;
  logic [2*DATA_W:0]    working_next;
  logic [DATA_W-1:0]    quot_fin;
  logic [DATA_W-1:0]    rem_fin;

  always_comb begin
    abs1 = opdata1_i;
    abs2 = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) abs1 = {DATA_W{1'b0}} - opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) abs2 = {DATA_W{1'b0}} - opdata2_i;
  end

  // Trial subtraction of the divisor from the upper half; a borrow means the bit is 0.
  always_comb begin
    diff = working_reg[2*DATA_W:DATA_W] - {1'b0, divisor_reg};
    if (diff[DATA_W])
      working_next = {working_reg[2*DATA_W-1:0], 1'b0};
    else
      working_next = {diff[DATA_W-1:0], working_reg[DATA_W-1:0], 1'b1};
  end

  always_comb begin
    quot_fin = working_reg[DATA_W-1:0];
    rem_fin  = working_reg[2*DATA_W:DATA_W+1];
    if (signed_reg && (sign1_reg ^ sign2_reg)) quot_fin = {DATA_W{1'b0}} - working_reg[DATA_W-1:0];
    if (signed_reg && sign1_reg) rem_fin = {DATA_W{1'b0}} - working_reg[2*DATA_W:DATA_W+1];
  end

  assign stallreq_o = (start_i & ~ready_o & ~annul_i) ? Stop : ~Stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= DivFree;
      cnt_reg     <= '0;
      working_reg <= '0;
      divisor_reg <= '0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      signed_reg  <= 1'b0;
      ready_o     <= DivResultNotReady;
      result_o    <= '0;
    end else begin
      case (state_reg)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_reg <= DivByZero;
            end else begin
              state_reg   <= DivOn;
              cnt_reg     <= '0;
              working_reg <= {{DATA_W{1'b0}}, abs1, 1'b0};
              divisor_reg <= abs2;
              sign1_reg   <= opdata1_i[DATA_W-1];
              sign2_reg   <= opdata2_i[DATA_W-1];
              signed_reg  <= signed_div_i;
            end
          end
        end
        DivByZero: begin
          working_reg <= '0;
          result_o    <= '0;
          state_reg   <= DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state_reg <= DivFree;
            ready_o   <= DivResultNotReady;
            result_o  <= '0;
          end else if (cnt_reg != CW'(DATA_W)) begin
            working_reg <= working_next;
            cnt_reg     <= cnt_reg + CW'(1);
          end else begin
            result_o  <= {rem_fin, quot_fin};
            ready_o   <= DivResultReady;
            state_reg <= DivEnd;
          end
        end
        DivEnd: begin
          // Result stays valid until EX drops start, so the instruction advances once.
          if (annul_i || start_i == DivStop) begin
            state_reg <= DivFree;
            ready_o   <= DivResultNotReady;
            result_o  <= '0;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: state_reg <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divisions
// checked against plain 64-bit integer division.
module tb_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          stallreq_o;

  int errors = 0;
  int checks = 0;

  div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one division with start held; optionally scrambles operands mid-flight
  // and optionally finishes with an asynchronous reset instead of dropping start.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input bit reset_at_end);
    logic [63:0] exp;
    int lat, n, stall_cnt;
    bit stall_bad;
    exp = ref_div(sg, a, b);
    lat = (b == 32'd0) ? 2 : W + 1;
    @(negedge clk);
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    #1;
    check("stall_at_start", {63'd0, stallreq_o}, 64'd1);
    @(posedge clk); #1;
    stall_cnt = stallreq_o ? 1 : 0;
    stall_bad = 1'b0;
    if (scramble) begin
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sg;
    end
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (stallreq_o) stall_cnt++;
    end
    if (ready_o && stallreq_o !== 1'b0) stall_bad = 1'b1;
    $display("div signed=%0d a=%h b=%h result=%h expected=%h cycles=%0d", sg, a, b, result_o, exp, n);
    check("latency", 64'(n), 64'(lat));
    check("result", result_o, exp);
    check("stall_cycles", 64'(stall_cnt), 64'(lat));
    check("stall_drops_with_ready", {63'd0, stall_bad}, 64'd0);
    @(posedge clk); #1;
    check("hold_ready", {63'd0, ready_o}, 64'd1);
    check("hold_result", result_o, exp);
    if (reset_at_end) begin
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_rst_ready", {63'd0, ready_o}, 64'd0);
      check("async_rst_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      check("drop_ready", {63'd0, ready_o}, 64'd0);
      check("drop_result", result_o, 64'd0);
    end
  endtask

  initial begin
    bit saw_ready;
    logic [31:0] a, b;
    logic sg;

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    run_div(1'b1, -32'sd7, 32'd2, 1'b1, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div(1'b0, 32'h1234_5678, 32'd0, 1'b1, 1'b0);

    // Annul at iteration 10: division abandoned, no result ever appears.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    #1;
    check("annul_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul_no_ready", {63'd0, saw_ready}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

    // Async reset at iteration 20, then a clean division.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrun_rst_ready", {63'd0, ready_o}, 64'd0);
    check("midrun_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    check("rst_dropped_division", {63'd0, saw_ready}, 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);

    // Async reset while a finished result is held: outputs must clear before any edge.
    run_div(1'b1, 32'd1000, -32'sd3, 1'b0, 1'b1);
    run_div(1'b1, -32'sd7, 32'd2, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      a = $urandom;
      if (i % 6 == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        3: b = 32'hFFFF_FFFF - $urandom_range(0, 9);
        default: b = $urandom >> $urandom_range(1, 30);
      endcase
      run_div(sg, a, b, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
